// File: rtl/cic_pdm_modulator.sv
// Interpolating CIC (combs at sample rate, integrators at clk rate) driving a first-order PDM modulator.
// Define CIC_PDM_DITHER_EN to add a 16-bit LFSR carry-in dither to the modulator accumulator.

module cic_pdm_modulator #(
    parameter int STAGES      = 2,
    parameter int LOG2_INTERP = 2,
    parameter int WIDTH_IN    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH_IN-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                pdm_out,
    output logic                sample_tick,
    output logic                underrun,
    input  logic                underrun_clr
);

    localparam int INTERP     = 1 << LOG2_INTERP;
    localparam int SHIFT      = (STAGES - 1) * LOG2_INTERP;
    localparam int WIDTH_REGS = WIDTH_IN + SHIFT;
    localparam logic [LOG2_INTERP-1:0] LAST_PHASE = LOG2_INTERP'(INTERP - 1);

    logic [LOG2_INTERP-1:0] ctr_q, ctr_d;
    logic [WIDTH_IN-1:0]    held_q, held_d;
    logic [WIDTH_REGS-1:0]  comb_dly_q [STAGES];
    logic [WIDTH_REGS-1:0]  comb_dly_d [STAGES];
    logic [WIDTH_REGS-1:0]  stuff_q, stuff_d;
    logic [WIDTH_REGS-1:0]  integ_q [STAGES];
    logic [WIDTH_REGS-1:0]  integ_d [STAGES];
    logic [WIDTH_IN-1:0]    acc_q, acc_d;
    logic                   pdm_q, pdm_d;
    logic                   underrun_q, underrun_d;

    logic                   load;
    logic                   stuff_sel;
    logic [WIDTH_IN-1:0]    sample_x;
    logic [WIDTH_REGS-1:0]  comb_val;
    logic [WIDTH_REGS-1:0]  integ_val;
    logic [WIDTH_IN-1:0]    mod_v;
    logic [WIDTH_IN:0]      mod_sum;
    logic                   carry_in;

    always_comb begin
        ctr_d     = ctr_q + LOG2_INTERP'(1);
        load      = (ctr_q == LAST_PHASE);
        stuff_sel = (ctr_q == '0);
    end

    assign in_ready    = load;
    assign sample_tick = load;

    // A missed slot reuses the held sample so the comb chain sees a repeat, not a zero.
    always_comb begin
        sample_x = in_valid ? in_data : held_q;
        held_d   = load ? sample_x : held_q;
        comb_val = WIDTH_REGS'(sample_x);
        for (int k = 0; k < STAGES; k++) begin
            comb_dly_d[k] = load ? comb_val : comb_dly_q[k];
            comb_val      = comb_val - comb_dly_q[k];
        end
        stuff_d = load ? comb_val : stuff_q;
    end

    always_comb begin
        integ_val = stuff_sel ? stuff_q : '0;
        for (int k = 0; k < STAGES; k++) begin
            integ_val  = integ_val + integ_q[k];
            integ_d[k] = integ_val;
        end
        mod_v = WIDTH_IN'(integ_val >> SHIFT);
    end

`ifdef CIC_PDM_DITHER_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign carry_in = lfsr_q[0];
`else
    assign carry_in = 1'b0;
`endif

    // The accumulator overflow is the PDM bit; the remainder is the fed-back error.
    always_comb begin
        mod_sum = {1'b0, acc_q} + {1'b0, mod_v} + {{WIDTH_IN{1'b0}}, carry_in};
        acc_d   = mod_sum[WIDTH_IN-1:0];
        pdm_d   = mod_sum[WIDTH_IN];
    end

    always_comb begin
        underrun_d = underrun_q;
        if (load && !in_valid) begin
            underrun_d = 1'b1;
        end
        if (underrun_clr) begin
            underrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctr_q      <= '0;
            held_q     <= '0;
            stuff_q    <= '0;
            acc_q      <= '0;
            pdm_q      <= 1'b0;
            underrun_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                comb_dly_q[k] <= '0;
                integ_q[k]    <= '0;
            end
        end else begin
            ctr_q      <= ctr_d;
            held_q     <= held_d;
            stuff_q    <= stuff_d;
            acc_q      <= acc_d;
            pdm_q      <= pdm_d;
            underrun_q <= underrun_d;
            for (int k = 0; k < STAGES; k++) begin
                comb_dly_q[k] <= comb_dly_d[k];
                integ_q[k]    <= integ_d[k];
            end
        end
    end

    assign pdm_out  = pdm_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_cic_pdm_modulator.sv
// Self-checking bench for cic_pdm_modulator: directed density tests plus randomized traffic,
// checked every cycle against a convolution-based reference of the CIC and an ideal accumulator modulator.

module tb_cic_pdm_modulator;

    localparam int STAGES      = 2;
    localparam int LOG2_INTERP = 2;
    localparam int WIDTH_IN    = 8;
    localparam int INTERP      = 1 << LOG2_INTERP;
    localparam int SHIFT       = (STAGES - 1) * LOG2_INTERP;
    localparam int WIDTH_REGS  = WIDTH_IN + SHIFT;
    localparam int KLEN        = STAGES * (INTERP - 1) + 1;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [WIDTH_IN-1:0] inData;
    logic                inValid;
    logic                inReady;
    logic                pdmOut;
    logic                sampleTick;
    logic                underrun;
    logic                underrunClr;

    cic_pdm_modulator #(
        .STAGES      (STAGES),
        .LOG2_INTERP (LOG2_INTERP),
        .WIDTH_IN    (WIDTH_IN)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (inData),
        .in_valid     (inValid),
        .in_ready     (inReady),
        .pdm_out      (pdmOut),
        .sample_tick  (sampleTick),
        .underrun     (underrun),
        .underrun_clr (underrunClr)
    );

    always #5 clk = ~clk;

    int          compared   = 0;
    int          mismatched = 0;
    int          kernel [KLEN];
    int          sampleHist [$];
    int          cycleNum;
    int          heldModel;
    int          accModel;
    int          onesCount;
    bit          pdmModel;
    bit          underrunModel;
    logic [15:0] lfsrModel;

    // The interpolator's impulse response at clk rate is an INTERP-long boxcar convolved STAGES times.
    task automatic buildKernel();
        int tmp [KLEN];
        int len = 1;
        for (int i = 0; i < KLEN; i++) kernel[i] = 0;
        kernel[0] = 1;
        for (int s = 0; s < STAGES; s++) begin
            for (int i = 0; i < KLEN; i++) tmp[i] = 0;
            for (int i = 0; i < len; i++)
                for (int j = 0; j < INTERP; j++)
                    tmp[i + j] += kernel[i];
            len = len + INTERP - 1;
            for (int i = 0; i < KLEN; i++) kernel[i] = tmp[i];
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cycleNum, observed, expected);
        end
    endtask

    // Sample m (loaded at cycle INTERP*m+INTERP-1) starts contributing INTERP cycles after its slot start.
    function automatic int cicOutput(input int t);
        int y = 0;
        int start = (t - INTERP - KLEN) / INTERP;
        if (start < 0) start = 0;
        for (int m = start; m < sampleHist.size(); m++) begin
            int idx = t - INTERP * m - INTERP;
            if (idx >= 0 && idx < KLEN) y += sampleHist[m] * kernel[idx];
        end
        return y % (1 << WIDTH_REGS);
    endfunction

    task automatic resetModel();
        cycleNum      = 0;
        sampleHist.delete();
        heldModel     = 0;
        accModel      = 0;
        pdmModel      = 1'b0;
        underrunModel = 1'b0;
        lfsrModel     = 16'hACE1;
    endtask

    task automatic advanceModel(input bit valid, input int data, input bit clr);
        bit isLoad = (cycleNum % INTERP) == INTERP - 1;
        int v;
        int sum;
        bit cin = 1'b0;
        if (isLoad) begin
            heldModel = valid ? data : heldModel;
            sampleHist.push_back(heldModel);
        end
        if (clr) underrunModel = 1'b0;
        else if (isLoad && !valid) underrunModel = 1'b1;
`ifdef CIC_PDM_DITHER_EN
        cin = lfsrModel[0];
        lfsrModel = {lfsrModel[0] ^ lfsrModel[2] ^ lfsrModel[3] ^ lfsrModel[5], lfsrModel[15:1]};
`endif
        v = cicOutput(cycleNum) >> SHIFT;
        sum = accModel + v + int'(cin);
        pdmModel = sum >= (1 << WIDTH_IN);
        accModel = sum % (1 << WIDTH_IN);
        cycleNum++;
    endtask

    // Entered and left at a negedge: check this cycle's outputs, drive its inputs, step the model.
    task automatic applyStimulus(input bit valid, input int data, input bit clr, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            bit tick = (cycleNum % INTERP) == INTERP - 1;
            checkOutput("in_ready", 32'(inReady), 32'(tick));
            checkOutput("sample_tick", 32'(sampleTick), 32'(tick));
            checkOutput("pdm_out", 32'(pdmOut), 32'(pdmModel));
            checkOutput("underrun", 32'(underrun), 32'(underrunModel));
            onesCount += int'(pdmOut);
            inValid     = valid;
            inData      = WIDTH_IN'(data);
            underrunClr = clr;
            advanceModel(valid, data, clr);
            @(negedge clk);
        end
    endtask

    task automatic doReset(input int holdCycles);
        rst_n       = 1'b0;
        inValid     = 1'b0;
        underrunClr = 1'b0;
        repeat (holdCycles) @(negedge clk);
        rst_n = 1'b1;
        resetModel();
    endtask

    task automatic alignTo(input int phase, input int data);
        while ((cycleNum % INTERP) != phase) applyStimulus(1'b1, data, 1'b0, 1);
    endtask

    task automatic densityWindow(input string tag, input int data, input int settle, input int window,
                                 input int expected, input int tol);
        applyStimulus(1'b1, data, 1'b0, settle);
        onesCount = 0;
        applyStimulus(1'b1, data, 1'b0, window);
        checkOutput(tag, (onesCount >= expected - tol && onesCount <= expected + tol) ? expected : onesCount,
                    expected);
    endtask

    initial begin
        rst_n       = 1'b0;
        inValid     = 1'b0;
        inData      = '0;
        underrunClr = 1'b0;
        onesCount   = 0;
        buildKernel();
        @(negedge clk);
        doReset(3);

        // Silence, then the fixed-density cases.
        densityWindow("zero_density", 0, 0, 1000, 0, 0);
`ifndef CIC_PDM_DITHER_EN
        densityWindow("half_density", 128, 64, 1024, 512, 0);
        densityWindow("quarter_density", 64, 64, 1024, 256, 0);
        densityWindow("full_density", 255, 64, 1024, 1020, 0);
        applyStimulus(1'b1, 0, 1'b0, 64);
        densityWindow("step_200_density", 200, 16, 2560, 2000, 1);
`else
        applyStimulus(1'b1, 128, 1'b0, 3000);
`endif

        // Missed slot: sticky flag, repeated sample, clear, then clear racing a new underrun.
        applyStimulus(1'b1, 100, 1'b0, 64);
        alignTo(INTERP - 1, 100);
        applyStimulus(1'b0, 0, 1'b0, 1);
        checkOutput("underrun_set", 32'(underrun), 32'd1);
`ifndef CIC_PDM_DITHER_EN
        densityWindow("underrun_repeat_density", 100, 0, 512, 200, 0);
`else
        applyStimulus(1'b1, 100, 1'b0, 512);
`endif
        applyStimulus(1'b1, 100, 1'b1, 1);
        checkOutput("underrun_cleared", 32'(underrun), 32'd0);
        alignTo(INTERP - 1, 100);
        applyStimulus(1'b0, 0, 1'b0, 1);
        applyStimulus(1'b1, 100, 1'b0, 8);
        alignTo(INTERP - 1, 100);
        applyStimulus(1'b0, 0, 1'b1, 1);
        checkOutput("underrun_clr_priority", 32'(underrun), 32'd0);
        applyStimulus(1'b1, 100, 1'b0, 8);

        // One-cycle reset in the middle of a stream.
        applyStimulus(1'b1, 100, 1'b0, 37);
        doReset(1);
        checkOutput("midreset_pdm", 32'(pdmOut), 32'd0);
        checkOutput("midreset_ready", 32'(inReady), 32'd0);
        checkOutput("midreset_underrun", 32'(underrun), 32'd0);
        applyStimulus(1'b1, 100, 1'b0, 300);

        // Randomized traffic with occasional underruns, clears and resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) == 0) doReset(1);
            applyStimulus($urandom_range(0, 7) != 0, int'($urandom_range(0, 255)),
                          $urandom_range(0, 15) == 0, 1);
        end

`ifdef CIC_PDM_DITHER_EN
        doReset(3);
        densityWindow("dither_half_density", 128, 64, 4096, 2056, 8);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
